// File: rtl/zeroheti_pkg.sv
// Shared types for the zeroheti OBI manager arbiter.
//   mgr_idx_e  : index of an upstream OBI manager (core data port or debug SBA)
//   NumBusMgr  : number of upstream managers merged onto one bus port
//   other_mgr  : returns the index of the manager that is not the argument
package zeroheti_pkg;

    typedef enum logic [0:0] {
        MgrCore,
        MgrSba
    } mgr_idx_e;

    localparam int unsigned NumBusMgr = 2;

    // With exactly two managers, "the other one" is a simple flip.
    function automatic mgr_idx_e other_mgr(mgr_idx_e idx);
        return (idx == MgrCore) ? MgrSba : MgrCore;
    endfunction

endpackage

// File: rtl/zeroheti_obi_mgr_arb_if.sv
// OBI bus bundle (request + response channels).
//   Manager     : drives req/addr/we/be/wdata/aid, receives gnt/rvalid/rdata/rid/err
//   Subordinate : mirror of Manager
interface OBI_BUS #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdWidth   = 1
) ();

    localparam int unsigned BeWidth = DataWidth / 8;

    // request channel
    logic                 req;
    logic                 gnt;
    logic [AddrWidth-1:0] addr;
    logic                 we;
    logic [BeWidth-1:0]   be;
    logic [DataWidth-1:0] wdata;
    logic [IdWidth-1:0]   aid;

    // response channel
    logic                 rvalid;
    logic [DataWidth-1:0] rdata;
    logic [IdWidth-1:0]   rid;
    logic                 err;

    modport Manager (
        output req, addr, we, be, wdata, aid,
        input  gnt, rvalid, rdata, rid, err
    );

    modport Subordinate (
        input  req, addr, we, be, wdata, aid,
        output gnt, rvalid, rdata, rid, err
    );

endinterface

// File: rtl/zeroheti_src_fifo.sv
// Ordered record of which manager owns each granted, still-unanswered transaction.
//   clk_i, rst_ni : clock, asynchronous active-low reset (reset empties the FIFO)
//   push_i/data_i : append a manager index (ignored when full)
//   pop_i         : drop the head entry (ignored when empty)
//   full_o        : registered, Depth entries held
//   empty_o       : registered, no entries held
//   head_c        : combinational read of the oldest entry
module zeroheti_src_fifo
    import zeroheti_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     push_i,
    input  mgr_idx_e data_i,
    input  logic     pop_i,
    output logic     full_o,
    output logic     empty_o,
    output mgr_idx_e head_c
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth = $clog2(Depth + 1);
    localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(Depth - 1);
    localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);

    mgr_idx_e            mem_q [Depth];
    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                full_d, empty_d;
    logic                do_push, do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PtrWidth-1:0] next_ptr(logic [PtrWidth-1:0] ptr);
        return (ptr == LastPtr) ? '0 : ptr + PtrWidth'(1);
    endfunction

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_c  = mem_q[rd_ptr_q];

    // Next-state: pointers, occupancy and the registered flags derived from it.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + CntWidth'(do_push) - CntWidth'(do_pop);
        if (do_push) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        full_d  = (cnt_d == DepthCnt);
        empty_d = (cnt_d == '0);
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_o   <= 1'b0;
            empty_o  <= 1'b1;
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= MgrCore;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_o   <= full_d;
            empty_o  <= empty_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

endmodule

// File: rtl/zeroheti_obi_mgr_arb.sv
// Two-to-one OBI manager arbiter: merges the core data port (source 0) and the
// debug SBA manager (source 1) onto one OBI manager port. Round-robin between
// simultaneous requesters, holds a stalled request's source until it is granted,
// and routes in-order responses back to the owning source.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   core_sbr      : OBI subordinate port from the core data port
//   sba_sbr       : OBI subordinate port from the debug SBA manager
//   bus_mgr       : merged OBI manager port toward the interconnect
module zeroheti_obi_mgr_arb
    import zeroheti_pkg::*;
#(
    parameter int unsigned MaxTrans  = 2,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdWidth   = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    OBI_BUS.Subordinate core_sbr,
    OBI_BUS.Subordinate sba_sbr,
    OBI_BUS.Manager     bus_mgr
);

    localparam int unsigned BeWidth = DataWidth / 8;

    localparam logic [0:0] LockIdle = 1'b0;
    localparam logic [0:0] LockHeld = 1'b1;

    mgr_idx_e             prio_q, prio_d;
    mgr_idx_e             lock_src_q, lock_src_d;
    logic [0:0]           lock_q, lock_d;
    mgr_idx_e             sel;
    mgr_idx_e             head;
    logic                 fifo_full, fifo_empty;

    logic                 sel_req;
    logic [AddrWidth-1:0] sel_addr;
    logic                 sel_we;
    logic [BeWidth-1:0]   sel_be;
    logic [DataWidth-1:0] sel_wdata;
    logic [IdWidth-1:0]   sel_aid;

    logic                 fwd_req, handshake, resp_ok;
    logic                 core_resp, sba_resp;

    // Source selection: a stalled request keeps its source; otherwise round-robin.
    always_comb begin
        sel = MgrCore;
        if (lock_q == LockHeld) begin
            sel = lock_src_q;
        end else if (core_sbr.req && sba_sbr.req) begin
            sel = prio_q;
        end else if (sba_sbr.req) begin
            sel = MgrSba;
        end
    end

    // Request payload mux.
    always_comb begin
        sel_req   = core_sbr.req;
        sel_addr  = core_sbr.addr;
        sel_we    = core_sbr.we;
        sel_be    = core_sbr.be;
        sel_wdata = core_sbr.wdata;
        sel_aid   = core_sbr.aid;
        if (sel == MgrSba) begin
            sel_req   = sba_sbr.req;
            sel_addr  = sba_sbr.addr;
            sel_we    = sba_sbr.we;
            sel_be    = sba_sbr.be;
            sel_wdata = sba_sbr.wdata;
            sel_aid   = sba_sbr.aid;
        end
    end

    // Nothing is forwarded while the owner record is full; no rvalid bypass.
    assign fwd_req   = sel_req && !fifo_full;
    assign handshake = fwd_req && bus_mgr.gnt;

    assign bus_mgr.req   = fwd_req;
    assign bus_mgr.addr  = sel_addr;
    assign bus_mgr.we    = sel_we;
    assign bus_mgr.be    = sel_be;
    assign bus_mgr.wdata = sel_wdata;
    assign bus_mgr.aid   = sel_aid;

    assign core_sbr.gnt = bus_mgr.gnt && !fifo_full && (sel == MgrCore);
    assign sba_sbr.gnt  = bus_mgr.gnt && !fifo_full && (sel == MgrSba);

    // Priority and lock next-state.
    always_comb begin
        prio_d     = prio_q;
        lock_d     = lock_q;
        lock_src_d = lock_src_q;
        if (handshake) begin
            prio_d = other_mgr(sel);
            lock_d = LockIdle;
        end else if (fwd_req) begin
            lock_d     = LockHeld;
            lock_src_d = sel;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q     <= MgrCore;
            lock_q     <= LockIdle;
            lock_src_q <= MgrCore;
        end else begin
            prio_q     <= prio_d;
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
        end
    end

    zeroheti_src_fifo #(
        .Depth (MaxTrans)
    ) i_src_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (handshake),
        .data_i  (sel),
        .pop_i   (resp_ok),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_c  (head)
    );

    // A response with no outstanding transaction is dropped.
    assign resp_ok   = bus_mgr.rvalid && !fifo_empty;
    assign core_resp = resp_ok && (head == MgrCore);
    assign sba_resp  = resp_ok && (head == MgrSba);

    assign core_sbr.rvalid = core_resp;
    assign core_sbr.rdata  = core_resp ? bus_mgr.rdata : '0;
    assign core_sbr.rid    = core_resp ? bus_mgr.rid   : '0;
    assign core_sbr.err    = core_resp && bus_mgr.err;

    assign sba_sbr.rvalid = sba_resp;
    assign sba_sbr.rdata  = sba_resp ? bus_mgr.rdata : '0;
    assign sba_sbr.rid    = sba_resp ? bus_mgr.rid   : '0;
    assign sba_sbr.err    = sba_resp && bus_mgr.err;

endmodule

// File: tb/tb_zeroheti_obi_mgr_arb.sv
// Self-checking bench for zeroheti_obi_mgr_arb: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_zeroheti_obi_mgr_arb;

    localparam int MaxTrans = 2;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    OBI_BUS #(.AddrWidth(32), .DataWidth(32), .IdWidth(1)) core_bus ();
    OBI_BUS #(.AddrWidth(32), .DataWidth(32), .IdWidth(1)) sba_bus ();
    OBI_BUS #(.AddrWidth(32), .DataWidth(32), .IdWidth(1)) bus ();

    zeroheti_obi_mgr_arb #(
        .MaxTrans  (MaxTrans),
        .AddrWidth (32),
        .DataWidth (32),
        .IdWidth   (1)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .core_sbr (core_bus),
        .sba_sbr  (sba_bus),
        .bus_mgr  (bus)
    );

    int errors = 0;
    int checks = 0;
    int unexp  = 0;

    // Reference model: owner queue, round-robin pointer, stall lock.
    int m_q[$];
    int m_prio     = 0;
    bit m_lock     = 1'b0;
    int m_lock_src = 0;
    int n_sel      = 0;
    bit n_hs       = 1'b0;
    bit n_fwd      = 1'b0;
    bit n_pop      = 1'b0;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_core(input logic req, input logic [31:0] addr, input logic we,
                            input logic [31:0] wdata);
        core_bus.req   = req;
        core_bus.addr  = addr;
        core_bus.we    = we;
        core_bus.be    = we ? 4'hF : 4'h0;
        core_bus.wdata = wdata;
        core_bus.aid   = addr[4];
    endtask

    task automatic set_sba(input logic req, input logic [31:0] addr, input logic we,
                           input logic [31:0] wdata);
        sba_bus.req   = req;
        sba_bus.addr  = addr;
        sba_bus.we    = we;
        sba_bus.be    = we ? 4'hF : 4'h0;
        sba_bus.wdata = wdata;
        sba_bus.aid   = addr[4];
    endtask

    task automatic set_bus(input logic gnt, input logic rvalid, input logic [31:0] rdata,
                           input logic err);
        bus.gnt    = gnt;
        bus.rvalid = rvalid;
        bus.rdata  = rdata;
        bus.rid    = rdata[0];
        bus.err    = err;
    endtask

    task automatic idle();
        set_core(1'b0, 32'h0, 1'b0, 32'h0);
        set_sba(1'b0, 32'h0, 1'b0, 32'h0);
        set_bus(1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    // Compare every DUT output against the model for the current inputs.
    task automatic eval();
        int  sel;
        int  owner;
        bit  full;
        bit  fwd;
        full = (m_q.size() == MaxTrans);
        if (m_lock) sel = m_lock_src;
        else if (core_bus.req && sba_bus.req) sel = m_prio;
        else if (sba_bus.req) sel = 1;
        else sel = 0;
        fwd = ((sel == 1) ? sba_bus.req : core_bus.req) && !full;
        chk1("bus_req", bus.req, fwd);
        chk1("core_gnt", core_bus.gnt, bus.gnt && !full && (sel == 0));
        chk1("sba_gnt", sba_bus.gnt, bus.gnt && !full && (sel == 1));
        if (fwd) begin
            chk32("bus_addr", bus.addr, (sel == 1) ? sba_bus.addr : core_bus.addr);
            chk32("bus_wdata", bus.wdata, (sel == 1) ? sba_bus.wdata : core_bus.wdata);
            chk1("bus_we", bus.we, (sel == 1) ? sba_bus.we : core_bus.we);
            chk1("bus_aid", bus.aid[0], (sel == 1) ? sba_bus.aid[0] : core_bus.aid[0]);
        end
        owner = -1;
        if (bus.rvalid && m_q.size() > 0) owner = m_q[0];
        if (bus.rvalid && m_q.size() == 0) begin
            unexp++;
            $display("note: unexpected response with nothing outstanding at %0t", $time);
        end
        chk1("core_rvalid", core_bus.rvalid, owner == 0);
        chk1("sba_rvalid", sba_bus.rvalid, owner == 1);
        chk32("core_rdata", core_bus.rdata, (owner == 0) ? bus.rdata : 32'h0);
        chk32("sba_rdata", sba_bus.rdata, (owner == 1) ? bus.rdata : 32'h0);
        chk1("core_err", core_bus.err, (owner == 0) && bus.err);
        chk1("sba_err", sba_bus.err, (owner == 1) && bus.err);
        chk1("core_rid", core_bus.rid[0], (owner == 0) && bus.rid[0]);
        chk1("sba_rid", sba_bus.rid[0], (owner == 1) && bus.rid[0]);
        n_sel = sel;
        n_fwd = fwd;
        n_hs  = fwd && bus.gnt;
        n_pop = (owner >= 0);
    endtask

    task automatic settle();
        #1;
        eval();
    endtask

    // Clock edge, then apply the model's state change for the cycle just evaluated.
    task automatic advance();
        @(posedge clk_i);
        #1;
        if (n_pop) void'(m_q.pop_front());
        if (n_hs) begin
            m_q.push_back(n_sel);
            m_prio = 1 - n_sel;
            m_lock = 1'b0;
        end else if (n_fwd) begin
            m_lock     = 1'b1;
            m_lock_src = n_sel;
        end
        n_hs  = 1'b0;
        n_fwd = 1'b0;
        n_pop = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_ni = 1'b0;
        m_q.delete();
        m_prio = 0;
        m_lock = 1'b0;
        n_hs   = 1'b0;
        n_fwd  = 1'b0;
        n_pop  = 1'b0;
        #1;
        chk1("rst_bus_req", bus.req, 1'b0);
        chk1("rst_core_gnt", core_bus.gnt, 1'b0);
        chk1("rst_sba_gnt", sba_bus.gnt, 1'b0);
        chk1("rst_core_rvalid", core_bus.rvalid, 1'b0);
        chk1("rst_sba_rvalid", sba_bus.rvalid, 1'b0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        bit cp;
        bit sp;

        // Core read alone.
        do_reset();
        set_core(1'b1, 32'h1000_0000, 1'b0, 32'h0);
        set_bus(1'b1, 1'b0, 32'h0, 1'b0);
        settle();
        chk1("t1_core_gnt", core_bus.gnt, 1'b1);
        advance();
        set_core(1'b0, 32'h0, 1'b0, 32'h0);
        set_bus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        settle();
        chk1("t1_core_rvalid", core_bus.rvalid, 1'b1);
        chk32("t1_core_rdata", core_bus.rdata, 32'hDEAD_BEEF);
        chk1("t1_sba_rvalid", sba_bus.rvalid, 1'b0);
        advance();

        // Simultaneous requests after reset: core, SBA, core; responses in order.
        do_reset();
        set_core(1'b1, 32'h0000_0100, 1'b0, 32'h0);
        set_sba(1'b1, 32'h0000_0200, 1'b0, 32'h0);
        set_bus(1'b1, 1'b0, 32'h0, 1'b0);
        settle();
        chk1("t2_c0_core_gnt", core_bus.gnt, 1'b1);
        chk1("t2_c0_sba_gnt", sba_bus.gnt, 1'b0);
        advance();
        set_core(1'b1, 32'h0000_0104, 1'b0, 32'h0);
        set_bus(1'b1, 1'b1, 32'hAAAA_0001, 1'b0);
        settle();
        chk1("t2_c1_sba_gnt", sba_bus.gnt, 1'b1);
        chk1("t2_c1_core_gnt", core_bus.gnt, 1'b0);
        chk32("t2_resp_a", core_bus.rdata, 32'hAAAA_0001);
        advance();
        set_sba(1'b0, 32'h0, 1'b0, 32'h0);
        set_bus(1'b1, 1'b1, 32'hBBBB_0002, 1'b0);
        settle();
        chk1("t2_c2_core_gnt", core_bus.gnt, 1'b1);
        chk32("t2_resp_b", sba_bus.rdata, 32'hBBBB_0002);
        advance();
        set_core(1'b0, 32'h0, 1'b0, 32'h0);
        set_bus(1'b0, 1'b1, 32'hCCCC_0003, 1'b0);
        settle();
        chk32("t2_resp_c", core_bus.rdata, 32'hCCCC_0003);
        advance();

        // Lock: stalled SBA write keeps the bus while core starts requesting.
        do_reset();
        set_sba(1'b1, 32'h2000_0004, 1'b1, 32'h1234_5678);
        set_bus(1'b0, 1'b0, 32'h0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            if (c == 1) set_core(1'b1, 32'h3000_0000, 1'b0, 32'h0);
            if (c == 3) set_bus(1'b1, 1'b0, 32'h0, 1'b0);
            settle();
            chk32("t3_addr_held", bus.addr, 32'h2000_0004);
            chk1("t3_sba_gnt", sba_bus.gnt, c == 3);
            chk1("t3_core_gnt", core_bus.gnt, 1'b0);
            advance();
        end
        set_sba(1'b0, 32'h0, 1'b0, 32'h0);
        settle();
        chk1("t3_c4_core_gnt", core_bus.gnt, 1'b1);
        chk32("t3_c4_addr", bus.addr, 32'h3000_0000);
        advance();
        set_core(1'b0, 32'h0, 1'b0, 32'h0);
        set_bus(1'b0, 1'b1, 32'h0000_5151, 1'b0);
        settle();
        chk1("t3_resp_sba", sba_bus.rvalid, 1'b1);
        advance();
        set_bus(1'b0, 1'b1, 32'h0000_C0C0, 1'b0);
        settle();
        chk1("t3_resp_core", core_bus.rvalid, 1'b1);
        advance();

        // Full: third core request waits until one response has retired.
        do_reset();
        set_bus(1'b1, 1'b0, 32'h0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            set_core(1'b1, 32'h4000_0000 + 32'(c < 2 ? c * 4 : 8), 1'b0, 32'h0);
            if (c == 3) set_bus(1'b1, 1'b1, 32'h0000_0F01, 1'b0);
            if (c == 4) set_bus(1'b1, 1'b0, 32'h0, 1'b0);
            settle();
            chk1("t4_core_gnt", core_bus.gnt, (c < 2) || (c == 4));
            chk1("t4_bus_req", bus.req, (c < 2) || (c == 4));
            advance();
        end
        set_core(1'b0, 32'h0, 1'b0, 32'h0);
        for (int c = 0; c < 2; c++) begin
            set_bus(1'b0, 1'b1, 32'h0000_0F10 + 32'(c), 1'b0);
            settle();
            chk1("t4_drain_core_rvalid", core_bus.rvalid, 1'b1);
            advance();
        end

        // Error routing to SBA.
        do_reset();
        set_sba(1'b1, 32'h2000_0010, 1'b0, 32'h0);
        set_bus(1'b1, 1'b0, 32'h0, 1'b0);
        settle();
        advance();
        set_sba(1'b0, 32'h0, 1'b0, 32'h0);
        set_bus(1'b0, 1'b1, 32'hE000_0000, 1'b1);
        settle();
        chk1("t5_sba_err", sba_bus.err, 1'b1);
        chk1("t5_sba_rvalid", sba_bus.rvalid, 1'b1);
        chk1("t5_core_rvalid", core_bus.rvalid, 1'b0);
        advance();

        // Reset with two outstanding; a late response must reach nobody.
        do_reset();
        set_bus(1'b1, 1'b0, 32'h0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            set_core(1'b1, 32'h5000_0000 + 32'(c * 4), 1'b0, 32'h0);
            settle();
            advance();
        end
        do_reset();
        set_bus(1'b0, 1'b1, 32'h0BAD_0BAD, 1'b0);
        settle();
        chk1("t6_spurious_core", core_bus.rvalid, 1'b0);
        chk1("t6_spurious_sba", sba_bus.rvalid, 1'b0);
        advance();
        set_core(1'b1, 32'h5000_0100, 1'b0, 32'h0);
        set_bus(1'b1, 1'b0, 32'h0, 1'b0);
        settle();
        chk1("t6_post_core_gnt", core_bus.gnt, 1'b1);
        advance();
        set_core(1'b0, 32'h0, 1'b0, 32'h0);
        set_bus(1'b0, 1'b1, 32'h0000_600D, 1'b0);
        settle();
        chk1("t6_post_core_rvalid", core_bus.rvalid, 1'b1);
        advance();

        // Randomized traffic obeying OBI request stability.
        do_reset();
        cp = 1'b0;
        sp = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!cp) begin
                if (1'($urandom_range(0, 1))) begin
                    set_core(1'b1, $urandom, 1'($urandom_range(0, 1)), $urandom);
                    cp = 1'b1;
                end else begin
                    core_bus.req = 1'b0;
                end
            end
            if (!sp) begin
                if ($urandom_range(0, 2) == 0) begin
                    set_sba(1'b1, $urandom, 1'($urandom_range(0, 1)), $urandom);
                    sp = 1'b1;
                end else begin
                    sba_bus.req = 1'b0;
                end
            end
            set_bus($urandom_range(0, 9) < 7, (m_q.size() > 0) && ($urandom_range(0, 1) == 1),
                    $urandom, $urandom_range(0, 7) == 0);
            settle();
            if (n_hs && n_sel == 0) cp = 1'b0;
            if (n_hs && n_sel == 1) sp = 1'b0;
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
